ray_unit_queued: RTL and testbench
==================================

Name: ray_unit_queued

Overview:
Next-generation ray unit. Accepts rays through a ready/valid queue and runs them one at a time: octree traverse, step to the next cell, repeat, then write the pixel. Adds features the first-generation unit lacks: a bounded step budget, a background colour on miss or timeout, and an idle flag separate from input ready. Drives an external stepper and ray memory through start/done handshakes, and sits between the frame dispatcher and those units.

Parameters:
POSITION_WIDTH, 16, width of each ray coordinate (q, v, cell bounds)
DATA_WIDTH, 24, material/pixel width; material 0 = empty
ADDRESS_WIDTH, 32, pixel address width
DEPTH_WIDTH, 5, width of octree depth reported by memory
RAY_FIFO_DEPTH, 4, input queue entries; power of two, >=2
MAX_STEPS, 255, step budget per ray, >=1; STEP_WIDTH = clog2(MAX_STEPS+1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low (0 = reset)
rayValid  in  1  ray offered
rayReady  out  1  queue can accept
rayQ  in  3xPOSITION_WIDTH  ray origin
rayV  in  3xPOSITION_WIDTH  ray direction
rayPixelAddress  in  ADDRESS_WIDTH  destination pixel
background  in  DATA_WIDTH  miss/timeout colour, stable while !idle
idle  out  1  queue empty and FSM in IDLE
traverseStart  out  1  one-cycle request to memory
traversePosition  out  3xPOSITION_WIDTH  current q
traverseDone  in  1  memory result valid
traverseMaterial  in  DATA_WIDTH  material at position
traverseDepth  in  DEPTH_WIDTH  depth of leaf containing position
stepStart  out  1  one-cycle request to stepper
stepQ, stepV, stepL, stepU  out  3xPOSITION_WIDTH each  position, direction, cell low/high bounds
stepDone  in  1  stepper result valid
stepOutOfBounds  in  1  ray left the volume
stepQp  in  3xPOSITION_WIDTH  next position
writeStart  out  1  one-cycle pixel write request
writeAddress  out  ADDRESS_WIDTH  pixel address
writePixel  out  DATA_WIDTH  pixel value
writeDone  in  1  write accepted
raysCompleted  out  32  saturating count of writes done
raysTimedOut  out  16  saturating count of budget exhaustions

Behaviour:
- Reset (async assert, sync release): FIFO empty, FSM IDLE, all outputs 0 except rayReady=1 and idle=1. Counters clear. In-flight sub-unit transactions are abandoned; sub-units share this reset.
- FIFO: rayReady = !full, independent of same-cycle pop. Push on rayValid&rayReady. Order preserved; storage {q, v, address}.
- FSM states: IDLE, TRAVERSE_START, TRAVERSE_WAIT, STEP_START, STEP_WAIT, WRITE_START, WRITE_WAIT.
- IDLE: when FIFO is non-empty, pop, load q/v/address, clear stepCount, go to TRAVERSE_START.
  - A ray pushed at edge 0 gives traverseStart high in cycle 2.
- *_START: assert the matching start output for exactly one cycle, then move to *_WAIT.
- Done inputs are sampled only in the matching *_WAIT state and ignored elsewhere.
- TRAVERSE_WAIT on traverseDone:
  - Register depth = min(traverseDepth, POSITION_WIDTH).
  - Material != 0: writePixel = material, go to WRITE_START.
  - Otherwise go to STEP_START.
- STEP_WAIT on stepDone:
  - stepOutOfBounds: writePixel = background, go to WRITE_START.
  - Otherwise q <= stepQp and stepCount++.
  - If stepCount (after increment) == MAX_STEPS: writePixel = background, raysTimedOut++, go to WRITE_START.
  - Else go to TRAVERSE_START.
- WRITE_WAIT on writeDone: raysCompleted++, go to IDLE.
  - The next pop happens in IDLE, so there is one idle cycle between rays.
- Cell bounds, computed combinationally from registered q and depth:
  - mask = (1 << (POSITION_WIDTH - depth)) - 1, evaluated at POSITION_WIDTH+1 bits.
  - stepL[i] = q[i] & ~mask; stepU[i] = q[i] | mask.
- idle = FSM IDLE and FIFO empty. Counters hold at all-ones.
- traversePosition and stepQ always show the registered q; writeAddress and writePixel are held from WRITE_START until WRITE_WAIT exits.

Decomposition:
- Package ray_pkg:
  - position_t, vec3_t (3 x position_t), material_t
  - ray_unit_state_t enum
  - ray_entry_t struct {q, v, address}
  - function cell_mask(depth)
- Sub-module ray_fifo: synchronous FIFO of ray_entry_t, parameter DEPTH, with full/empty flags and an async active-low reset.

Test Plan:
- Hit on first traverse: push q=(0x1000,0x2000,0x3000), address 0x8000_0040; memory returns material 0x00FF00 -> one writeStart with writePixel 0x00FF00 and writeAddress 0x8000_0040; stepStart never asserts; raysCompleted=1.
- Cell bounds: q.x=0x1234 with depth 4 -> stepL.x=0x1000, stepU.x=0x1FFF. Depth 0 -> 0x0000/0xFFFF. Depth 16 and depth 20 -> stepL.x = stepU.x = 0x1234.
- Out-of-bounds: material 0, then stepper reports outOfBounds -> writePixel = background 0x202020; raysTimedOut stays 0.
- Timeout with MAX_STEPS=3 and constant misses -> exactly 3 traverseStart and 3 stepStart pulses, then background written; raysTimedOut=1.
- Backpressure with RAY_FIFO_DEPTH=4 and writeDone held low -> 5 rays accepted (1 in flight + 4 queued), rayReady low on the 6th. After releasing writeDone, write addresses appear in push order and idle returns to 1.
- Drive reset low during STEP_WAIT -> all outputs go 0 immediately except rayReady and idle; counters clear; a fresh push afterwards completes normally.

Source files
------------

// File: rtl/ray_pkg.sv
// Shared types for the queued ray unit: coordinates, ray queue entry, FSM states
// and the octree cell mask helper.
package ray_pkg;

  localparam int POS_W  = 16;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 32;
  localparam int LVL_W  = $clog2(POS_W + 1);

  typedef logic [POS_W-1:0]  position_t;
  typedef position_t [2:0]   vec3_t;
  typedef logic [DATA_W-1:0] material_t;
  typedef logic [ADDR_W-1:0] address_t;
  typedef logic [LVL_W-1:0]  level_t;

  typedef enum logic [2:0] {
    IDLE,
    TRAVERSE_START,
    TRAVERSE_WAIT,
    STEP_START,
    STEP_WAIT,
    WRITE_START,
    WRITE_WAIT
  } ray_unit_state_t;

  typedef struct packed {
    vec3_t    q;
    vec3_t    v;
    address_t address;
  } ray_entry_t;

  // Low bits that vary inside a leaf cell at the given depth; depth is pre-clamped to POS_W.
  function automatic position_t cell_mask(input level_t depth);
    logic [POS_W:0] one;
    logic [POS_W:0] m;
    one = (POS_W + 1)'(1);
    m   = (one << (POS_W - int'(depth))) - one;
    return m[POS_W-1:0];
  endfunction

endpackage

// File: rtl/ray_fifo.sv
// Ray input queue: order-preserving synchronous FIFO with full/empty flags.
// Push is ignored when full and pop when empty; head entry is visible combinationally.
module ray_fifo
  import ray_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  ray_entry_t i_dat,
  output ray_entry_t o_dat,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  ray_entry_t  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dat     = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/ray_unit_queued.sv
// Queued ray unit: pops one ray at a time and loops traverse/step until hit, exit or
// step budget, then writes the pixel. Sub-units are driven through one-cycle start pulses.
module ray_unit_queued
  import ray_pkg::*;
#(
  parameter int DEPTH_WIDTH    = 5,
  parameter int RAY_FIFO_DEPTH = 4,
  parameter int MAX_STEPS      = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rayValid,
  output logic                   rayReady,
  input  logic [3*POS_W-1:0]     rayQ,
  input  logic [3*POS_W-1:0]     rayV,
  input  logic [ADDR_W-1:0]      rayPixelAddress,
  input  logic [DATA_W-1:0]      background,
  output logic                   idle,
  output logic                   traverseStart,
  output logic [3*POS_W-1:0]     traversePosition,
  input  logic                   traverseDone,
  input  logic [DATA_W-1:0]      traverseMaterial,
  input  logic [DEPTH_WIDTH-1:0] traverseDepth,
  output logic                   stepStart,
  output logic [3*POS_W-1:0]     stepQ,
  output logic [3*POS_W-1:0]     stepV,
  output logic [3*POS_W-1:0]     stepL,
  output logic [3*POS_W-1:0]     stepU,
  input  logic                   stepDone,
  input  logic                   stepOutOfBounds,
  input  logic [3*POS_W-1:0]     stepQp,
  output logic                   writeStart,
  output logic [ADDR_W-1:0]      writeAddress,
  output logic [DATA_W-1:0]      writePixel,
  input  logic                   writeDone,
  output logic [31:0]            raysCompleted,
  output logic [15:0]            raysTimedOut
);

  localparam int STEP_WIDTH = $clog2(MAX_STEPS + 1);

  ray_entry_t             w_push_dat;
  ray_entry_t             w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  level_t                 w_depth_clamp;
  position_t              w_mask;
  vec3_t                  w_step_l;
  vec3_t                  w_step_u;
  logic [STEP_WIDTH-1:0]  w_step_next;
  logic                   w_budget_hit;

  ray_unit_state_t        r_state;
  vec3_t                  r_q;
  vec3_t                  r_v;
  address_t               r_addr;
  material_t              r_pixel;
  level_t                 r_depth;
  logic [STEP_WIDTH-1:0]  r_step_cnt;
  logic                   r_trav_start;
  logic                   r_step_start;
  logic                   r_write_start;
  logic [31:0]            r_completed;
  logic [15:0]            r_timed_out;

  assign w_push_dat = {rayQ, rayV, rayPixelAddress};
  assign w_pop      = (r_state == IDLE) && !w_empty;

  ray_fifo #(.DEPTH(RAY_FIFO_DEPTH)) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .i_push  (rayValid),
    .i_pop   (w_pop),
    .i_dat   (w_push_dat),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    if (int'(traverseDepth) > POS_W) w_depth_clamp = LVL_W'(POS_W);
    else                             w_depth_clamp = LVL_W'(traverseDepth);
  end

  always_comb begin
    w_mask = cell_mask(r_depth);
    for (int i = 0; i < 3; i++) begin
      w_step_l[i] = r_q[i] & ~w_mask;
      w_step_u[i] = r_q[i] | w_mask;
    end
  end

  assign w_step_next  = r_step_cnt + STEP_WIDTH'(1);
  assign w_budget_hit = (w_step_next == STEP_WIDTH'(MAX_STEPS));

  // Reset depth is a full-depth leaf so the bounds outputs read zero alongside q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_q           <= '0;
      r_v           <= '0;
      r_addr        <= '0;
      r_pixel       <= '0;
      r_depth       <= LVL_W'(POS_W);
      r_step_cnt    <= '0;
      r_trav_start  <= 1'b0;
      r_step_start  <= 1'b0;
      r_write_start <= 1'b0;
      r_completed   <= '0;
      r_timed_out   <= '0;
    end else begin
      r_trav_start  <= 1'b0;
      r_step_start  <= 1'b0;
      r_write_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_q          <= w_head.q;
            r_v          <= w_head.v;
            r_addr       <= w_head.address;
            r_step_cnt   <= '0;
            r_trav_start <= 1'b1;
            r_state      <= TRAVERSE_START;
          end
        end
        TRAVERSE_START: r_state <= TRAVERSE_WAIT;
        TRAVERSE_WAIT: begin
          if (traverseDone) begin
            r_depth <= w_depth_clamp;
            if (traverseMaterial != '0) begin
              r_pixel       <= traverseMaterial;
              r_write_start <= 1'b1;
              r_state       <= WRITE_START;
            end else begin
              r_step_start <= 1'b1;
              r_state      <= STEP_START;
            end
          end
        end
        STEP_START: r_state <= STEP_WAIT;
        STEP_WAIT: begin
          if (stepDone) begin
            if (stepOutOfBounds) begin
              r_pixel       <= background;
              r_write_start <= 1'b1;
              r_state       <= WRITE_START;
            end else begin
              r_q        <= stepQp;
              r_step_cnt <= w_step_next;
              if (w_budget_hit) begin
                r_pixel       <= background;
                r_write_start <= 1'b1;
                r_state       <= WRITE_START;
                if (r_timed_out != '1) r_timed_out <= r_timed_out + 16'd1;
              end else begin
                r_trav_start <= 1'b1;
                r_state      <= TRAVERSE_START;
              end
            end
          end
        end
        WRITE_START: r_state <= WRITE_WAIT;
        WRITE_WAIT: begin
          if (writeDone) begin
            if (r_completed != '1) r_completed <= r_completed + 32'd1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rayReady         = !w_full;
  assign idle             = (r_state == IDLE) && w_empty;
  assign traverseStart    = r_trav_start;
  assign traversePosition = r_q;
  assign stepStart        = r_step_start;
  assign stepQ            = r_q;
  assign stepV            = r_v;
  assign stepL            = w_step_l;
  assign stepU            = w_step_u;
  assign writeStart       = r_write_start;
  assign writeAddress     = r_addr;
  assign writePixel       = r_pixel;
  assign raysCompleted    = r_completed;
  assign raysTimedOut     = r_timed_out;

endmodule

// File: tb/tb_ray_unit_queued.sv
// Bench for ray_unit_queued: responders for memory/stepper/writer plus a per-ray
// outcome model; a single negedge process answers requests and checks every transaction.
module tb_ray_unit_queued;

  localparam int MAXS = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rayValid, rayReady, idle;
  logic [47:0] rayQ, rayV;
  logic [31:0] rayPixelAddress;
  logic [23:0] background;
  logic        traverseStart, traverseDone;
  logic [47:0] traversePosition;
  logic [23:0] traverseMaterial;
  logic [4:0]  traverseDepth;
  logic        stepStart, stepDone, stepOutOfBounds;
  logic [47:0] stepQ, stepV, stepL, stepU, stepQp;
  logic        writeStart, writeDone;
  logic [31:0] writeAddress;
  logic [23:0] writePixel;
  logic [31:0] raysCompleted;
  logic [15:0] raysTimedOut;

  always #5 clock = ~clock;

  ray_unit_queued #(.DEPTH_WIDTH(5), .RAY_FIFO_DEPTH(4), .MAX_STEPS(MAXS)) dut (
    .clock(clock), .reset(reset), .rayValid(rayValid), .rayReady(rayReady),
    .rayQ(rayQ), .rayV(rayV), .rayPixelAddress(rayPixelAddress), .background(background),
    .idle(idle), .traverseStart(traverseStart), .traversePosition(traversePosition),
    .traverseDone(traverseDone), .traverseMaterial(traverseMaterial), .traverseDepth(traverseDepth),
    .stepStart(stepStart), .stepQ(stepQ), .stepV(stepV), .stepL(stepL), .stepU(stepU),
    .stepDone(stepDone), .stepOutOfBounds(stepOutOfBounds), .stepQp(stepQp),
    .writeStart(writeStart), .writeAddress(writeAddress), .writePixel(writePixel),
    .writeDone(writeDone), .raysCompleted(raysCompleted), .raysTimedOut(raysTimedOut)
  );

  // Ray scenario: which traverse hits (or -1) and which step leaves the volume (or -1).
  typedef struct packed {
    logic [47:0] q;
    logic [47:0] v;
    logic [31:0] addr;
    int          hit_at;
    int          oob_at;
    logic [23:0] mat;
    logic [4:0]  depth;
  } ray_d;

  ray_d rq[$];
  int   n_chk = 0, n_fail = 0;

  int   cur_t = 0, cur_s = 0, tr_cnt = 0, st_cnt = 0, tr_lat = 1, st_lat = 1;
  bit   tr_pend = 0, st_pend = 0, wr_pend = 0, wr_en = 1, cur_tmo = 0, st_oob_n = 0;
  logic [23:0] tr_mat_n;
  logic [47:0] st_qp_n;
  int   exp_done = 0, exp_tmo = 0;
  int   n_trav = 0, n_step = 0;
  logic [15:0] cap_l, cap_u;
  logic [23:0] cap_pix;
  logic [23:0] m_pix;
  int   m_ntr, m_nst, sh, comp, exp_l, exp_u;
  bit   m_tmo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] vadd(input logic [47:0] a, input logic [47:0] b, input int k);
    logic [47:0] r;
    int c;
    for (int i = 0; i < 3; i++) begin
      c = int'(a[16*i +: 16]) + k * int'(b[16*i +: 16]);
      r[16*i +: 16] = c[15:0];
    end
    return r;
  endfunction

  // Outcome of a ray from its scenario: walk traverse/step rounds until an exit rule fires.
  task automatic model_ray(input ray_d d, output logic [23:0] pix, output int ntr,
                           output int nst, output bit tmo);
    ntr = 0; nst = 0; tmo = 0; pix = '0;
    for (int t = 0; t < 1000; t++) begin
      ntr++;
      if (t == d.hit_at) begin pix = d.mat; return; end
      nst++;
      if (t == d.oob_at) begin pix = background; return; end
      if (nst == MAXS) begin pix = background; tmo = 1; return; end
    end
  endtask

  function automatic ray_d mk(input logic [15:0] qx, input logic [31:0] addr, input int hit,
                              input int oob, input logic [23:0] mat, input logic [4:0] dep);
    ray_d d;
    d.q = {16'h3000, 16'h2000, qx};
    d.v = {16'h0030, 16'hFFF0, 16'h0100};
    d.addr = addr; d.hit_at = hit; d.oob_at = oob; d.mat = mat; d.depth = dep;
    return d;
  endfunction

  always @(negedge clock) begin
    traverseDone = 1'b0; stepDone = 1'b0; writeDone = 1'b0;
    if (!reset) begin
      rq.delete();
      tr_pend = 0; st_pend = 0; wr_pend = 0; cur_t = 0; cur_s = 0;
      exp_done = 0; exp_tmo = 0;
    end else begin
      if (tr_pend) begin
        if (tr_cnt == 0) begin
          traverseDone = 1'b1; traverseMaterial = tr_mat_n; traverseDepth = rq[0].depth; tr_pend = 0;
        end else tr_cnt--;
      end
      if (st_pend) begin
        if (st_cnt == 0) begin
          stepDone = 1'b1; stepOutOfBounds = st_oob_n; stepQp = st_qp_n; st_pend = 0;
        end else st_cnt--;
      end
      if (wr_pend && wr_en) begin
        writeDone = 1'b1; wr_pend = 0;
        void'(rq.pop_front());
        exp_done++; exp_tmo += int'(cur_tmo); cur_t = 0; cur_s = 0;
      end
      if (traverseStart) begin
        n_trav++;
        chk("trav_has_ray", 64'(rq.size() > 0), 1);
        if (rq.size() > 0) begin
          chk("trav_position", traversePosition, vadd(rq[0].q, rq[0].v, cur_t));
          tr_mat_n = (cur_t == rq[0].hit_at) ? rq[0].mat : 24'h0;
          tr_pend = 1; tr_cnt = tr_lat; cur_t++;
        end
      end
      if (stepStart) begin
        n_step++;
        chk("step_has_ray", 64'(rq.size() > 0), 1);
        if (rq.size() > 0) begin
          chk("step_q", stepQ, vadd(rq[0].q, rq[0].v, cur_s));
          chk("step_v", stepV, rq[0].v);
          sh = 16 - ((rq[0].depth > 5'd16) ? 16 : int'(rq[0].depth));
          for (int i = 0; i < 3; i++) begin
            comp  = int'(stepQ[16*i +: 16]);
            exp_l = (comp >> sh) << sh;
            exp_u = exp_l + (1 << sh) - 1;
            chk("step_l", stepL[16*i +: 16], 64'(exp_l));
            chk("step_u", stepU[16*i +: 16], 64'(exp_u));
          end
          cap_l = stepL[15:0]; cap_u = stepU[15:0];
          st_qp_n = vadd(rq[0].q, rq[0].v, cur_s + 1);
          st_oob_n = (cur_s == rq[0].oob_at);
          st_pend = 1; st_cnt = st_lat; cur_s++;
        end
      end
      if (writeStart) begin
        chk("write_has_ray", 64'(rq.size() > 0), 1);
        if (rq.size() > 0) begin
          model_ray(rq[0], m_pix, m_ntr, m_nst, m_tmo);
          chk("write_address", writeAddress, rq[0].addr);
          chk("write_pixel", writePixel, m_pix);
          chk("traverse_rounds", 64'(cur_t), 64'(m_ntr));
          chk("step_rounds", 64'(cur_s), 64'(m_nst));
          cap_pix = writePixel; cur_tmo = m_tmo; wr_pend = 1;
        end
      end
    end
  end

  task automatic push(input ray_d d);
    bit acc = 0;
    rayQ = d.q; rayV = d.v; rayPixelAddress = d.addr; rayValid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (rayReady) begin acc = 1; @(negedge clock); break; end
      @(negedge clock);
    end
    rayValid = 1'b0;
    chk("push_accepted", 64'(acc), 1);
    if (acc) rq.push_back(d);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      if (idle && rq.size() == 0) begin ok = 1; break; end
    end
    chk(name, 64'(ok), 1);
  endtask

  logic [4:0]  dtab[4];
  logic [15:0] ltab[4], utab[4];
  int base_t, base_s;

  initial begin
    rayValid = 0; rayQ = '0; rayV = '0; rayPixelAddress = '0; background = 24'h202020;
    traverseMaterial = '0; traverseDepth = '0; stepOutOfBounds = 0; stepQp = '0;
    dtab = '{5'd4, 5'd0, 5'd16, 5'd20};
    ltab = '{16'h1000, 16'h0000, 16'h1234, 16'h1234};
    utab = '{16'h1FFF, 16'hFFFF, 16'h1234, 16'h1234};
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_rayReady", rayReady, 1);
    chk("reset_idle", idle, 1);
    chk("reset_traverseStart", traverseStart, 0);
    chk("reset_stepU", stepU, 0);
    chk("reset_completed", raysCompleted, 0);

    // Hit on first traverse
    base_s = n_step;
    push(mk(16'h1000, 32'h8000_0040, 0, -1, 24'h00FF00, 5'd3));
    chk("start_not_yet", traverseStart, 0);
    @(negedge clock);
    chk("start_cycle2", traverseStart, 1);
    wait_idle("idle_after_hit");
    chk("hit_pixel", cap_pix, 24'h00FF00);
    chk("hit_no_step", 64'(n_step - base_s), 0);
    chk("hit_completed", raysCompleted, 1);

    // Cell bounds at several depths, each ray leaving the volume on its first step
    for (int k = 0; k < 4; k++) begin
      push(mk(16'h1234, 32'h100 + 32'(k), -1, 0, 24'h0, dtab[k]));
      wait_idle("idle_after_bounds");
      chk("bounds_l", cap_l, ltab[k]);
      chk("bounds_u", cap_u, utab[k]);
    end
    push(mk(16'h0F00, 32'h200, -1, 1, 24'h0, 5'd8));
    wait_idle("idle_after_oob");
    chk("oob_pixel", cap_pix, 24'h202020);
    chk("oob_no_timeout", raysTimedOut, 0);
    chk("oob_completed", raysCompleted, 64'(exp_done));

    // Step budget exhaustion
    base_t = n_trav; base_s = n_step;
    push(mk(16'h4000, 32'h300, -1, -1, 24'h0, 5'd2));
    wait_idle("idle_after_timeout");
    chk("timeout_traverses", 64'(n_trav - base_t), 3);
    chk("timeout_steps", 64'(n_step - base_s), 3);
    chk("timeout_pixel", cap_pix, 24'h202020);
    chk("timeout_count", raysTimedOut, 1);
    chk("timeout_model_count", raysTimedOut, 64'(exp_tmo));

    // Backpressure: writes stalled, five rays fit, sixth refused
    wr_en = 0;
    for (int k = 0; k < 5; k++) push(mk(16'h0500, 32'hA000 + 32'(k), 0, -1, 24'(k + 1), 5'd1));
    rayQ = '0; rayPixelAddress = 32'hDEAD; rayValid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("sixth_refused", rayReady, 0);
      @(negedge clock);
    end
    rayValid = 1'b0;
    chk("busy_not_idle", idle, 0);
    wr_en = 1;
    wait_idle("idle_after_drain");
    chk("drain_idle", idle, 1);
    chk("drain_completed", raysCompleted, 64'(exp_done));

    // Reset while a step is outstanding
    st_lat = 30; base_s = n_step;
    push(mk(16'h7777, 32'h400, -1, -1, 24'h0, 5'd2));
    for (int c = 0; c < 100 && n_step == base_s; c++) @(negedge clock);
    chk("reached_step", 64'(n_step > base_s), 1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_traverseStart", traverseStart, 0);
    chk("rst_stepStart", stepStart, 0);
    chk("rst_writeStart", writeStart, 0);
    chk("rst_position", traversePosition, 0);
    chk("rst_stepV", stepV, 0);
    chk("rst_stepL", stepL, 0);
    chk("rst_stepU", stepU, 0);
    chk("rst_writeAddress", writeAddress, 0);
    chk("rst_writePixel", writePixel, 0);
    chk("rst_completed", raysCompleted, 0);
    chk("rst_timedout", raysTimedOut, 0);
    chk("rst_rayReady", rayReady, 1);
    chk("rst_idle", idle, 1);
    repeat (2) @(negedge clock);
    reset = 1'b1; st_lat = 1;
    @(negedge clock);
    push(mk(16'h0123, 32'h500, 1, -1, 24'h123456, 5'd5));
    wait_idle("idle_after_reset_ray");
    chk("post_reset_completed", raysCompleted, 1);
    chk("post_reset_timedout", raysTimedOut, 0);
    chk("post_reset_pixel", cap_pix, 24'h123456);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks made", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
